// File: rtl/merge_pass_engine_if.sv
// Host and bank-port bundle for merge_pass_engine: start/len/desc handshake, status,
// and the single-row read port / masked-row write port shared with the ping-pong banks.
interface merge_pass_engine_if #(
    parameter int KEY_WIDTH  = 64,
    parameter int LANES      = 2,
    parameter int ADDR_WIDTH = 10
);
    localparam int LEN_W = ADDR_WIDTH + $clog2(LANES) + 1;

    logic                       start_in;
    logic [LEN_W-1:0]           len_in;
    logic                       desc_in;
    logic                       busy_out;
    logic                       pass_done_out;
    logic                       done_out;
    logic                       pingpong_out;
    logic                       final_bank_out;
    logic                       rd_en_out;
    logic [ADDR_WIDTH-1:0]      rd_addr_out;
    logic [LANES*KEY_WIDTH-1:0] rd_data_in;
    logic                       wr_en_out;
    logic [ADDR_WIDTH-1:0]      wr_addr_out;
    logic [LANES*KEY_WIDTH-1:0] wr_data_out;
    logic [LANES-1:0]           wr_mask_out;

    modport master (
        input  start_in, len_in, desc_in, rd_data_in,
        output busy_out, pass_done_out, done_out, pingpong_out, final_bank_out,
               rd_en_out, rd_addr_out, wr_en_out, wr_addr_out, wr_data_out, wr_mask_out
    );

    modport slave (
        output start_in, len_in, desc_in, rd_data_in,
        input  busy_out, pass_done_out, done_out, pingpong_out, final_bank_out,
               rd_en_out, rd_addr_out, wr_en_out, wr_addr_out, wr_data_out, wr_mask_out
    );
endinterface

// File: rtl/merge_pass_engine.sv
// Bottom-up merge-sort engine: doubles the run width each pass, merging run pairs from the
// source bank into the destination bank until a single run covers the whole key count.
module merge_pass_engine #(
    parameter int KEY_WIDTH  = 64,
    parameter int LANES      = 2,
    parameter int ADDR_WIDTH = 10,
    parameter int START_RUN  = 16
) (
    input logic               clock,
    input logic               reset_n,
    merge_pass_engine_if.master bus
);
    localparam int LG    = $clog2(LANES);
    localparam int LEN_W = ADDR_WIDTH + LG + 1;
    localparam int IW    = LEN_W + 2;
    localparam int ROW_W = LANES * KEY_WIDTH;

    typedef logic [IW-1:0] idx_t;
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_MERGE, S_FLUSH, S_NEXT, S_DONE} state_t;

    localparam idx_t LANE_MASK = IW'(LANES - 1);
    localparam idx_t START_IDX = IW'(START_RUN);

    function automatic int lane_of(input idx_t idx);
        return int'(idx & LANE_MASK);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] row_of(input idx_t idx);
        return idx[LG +: ADDR_WIDTH];
    endfunction

    function automatic logic [KEY_WIDTH-1:0] key_of(input logic [ROW_W-1:0] row, input int lane);
        return row[lane*KEY_WIDTH +: KEY_WIDTH];
    endfunction

    function automatic idx_t min_idx(input idx_t a, input idx_t b);
        return (a < b) ? a : b;
    endfunction

    state_t           state, state_nxt;
    idx_t             len_q, w_q, base_q, out_idx_q;
    logic             desc_q, pingpong_q, final_bank_q;
    idx_t             head_q [2];
    idx_t             end_q  [2];
    logic [ROW_W-1:0] row_q  [2];
    logic             row_v_q[2];
    logic             pend_q, pend_side_q;
    logic [ROW_W-1:0] out_row_q;
    logic             wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [ROW_W-1:0] wr_data_q;
    logic [LANES-1:0] wr_mask_q;

    logic                 exh  [2];
    logic                 avail[2];
    logic [KEY_WIDTH-1:0] key  [2];
    logic                 emit, sel, last_emit, fetch0, fetch1;
    logic [KEY_WIDTH-1:0] sel_key;
    logic [ROW_W-1:0]     out_row_nxt;
    idx_t                 len_ext;

    assign len_ext = IW'(bus.len_in);

    // Merge datapath: a row arriving this cycle is bypassed straight into the compare.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        emit        = 1'b0;
        sel         = 1'b0;
        last_emit   = 1'b0;
        fetch0      = 1'b0;
        fetch1      = 1'b0;
        sel_key     = '0;
        out_row_nxt = out_row_q;
        for (int s = 0; s < 2; s++) begin
            exh[s]   = head_q[s] >= end_q[s];
            avail[s] = row_v_q[s] || (pend_q && pend_side_q == 1'(s));
            key[s]   = key_of((pend_q && pend_side_q == 1'(s)) ? bus.rd_data_in : row_q[s],
                              lane_of(head_q[s]));
        end
        if (state == S_MERGE) begin
            fetch0 = !exh[0] && !avail[0];
            fetch1 = !fetch0 && !exh[1] && !avail[1];
            emit   = !(exh[0] && exh[1]) && (exh[0] || avail[0]) && (exh[1] || avail[1]);
            // Exhaustion is a flag, so an all-ones key still competes normally; ties keep side 0.
            sel    = exh[0] || (!exh[1] && (desc_q ? (key[1] > key[0]) : (key[1] < key[0])));
        end
        sel_key = sel ? key[1] : key[0];
        if (sel) last_emit = emit && exh[0] && (head_q[1] + IW'(1) >= end_q[1]);
        else     last_emit = emit && exh[1] && (head_q[0] + IW'(1) >= end_q[0]);
        out_row_nxt[lane_of(out_idx_q)*KEY_WIDTH +: KEY_WIDTH] = sel_key;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start_in) state_nxt = (len_ext <= START_IDX) ? S_DONE : S_SETUP;
            S_SETUP: state_nxt = S_MERGE;
            S_MERGE: if (last_emit) state_nxt = (base_q + (w_q << 1) < len_q) ? S_SETUP : S_FLUSH;
            S_FLUSH: state_nxt = S_NEXT;
            S_NEXT:  state_nxt = ((w_q << 1) >= len_q) ? S_DONE : S_SETUP;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy_out       = state != S_IDLE;
        bus.pass_done_out  = state == S_NEXT;
        bus.done_out       = state == S_DONE;
        bus.final_bank_out = (state == S_DONE) ? pingpong_q : final_bank_q;
        bus.rd_en_out      = (state == S_SETUP) || fetch0 || fetch1;
        bus.rd_addr_out    = '0;
        if (state == S_SETUP) bus.rd_addr_out = row_of(base_q);
        else if (fetch1)      bus.rd_addr_out = row_of(head_q[1]);
        else if (fetch0)      bus.rd_addr_out = row_of(head_q[0]);
    end

    assign bus.pingpong_out = pingpong_q;
    assign bus.wr_en_out    = wr_en_q;
    assign bus.wr_addr_out  = wr_addr_q;
    assign bus.wr_data_out  = wr_data_q;
    assign bus.wr_mask_out  = wr_mask_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            len_q        <= '0;
            w_q          <= '0;
            base_q       <= '0;
            out_idx_q    <= '0;
            desc_q       <= 1'b0;
            pingpong_q   <= 1'b0;
            final_bank_q <= 1'b0;
            pend_q       <= 1'b0;
            pend_side_q  <= 1'b0;
            // NOTE: the row buffers are a handful of flops, not a RAM, so clearing them on reset is cheap.
            out_row_q    <= '0;
            for (int s = 0; s < 2; s++) begin
                head_q[s]  <= '0;
                end_q[s]   <= '0;
                row_q[s]   <= '0;
                row_v_q[s] <= 1'b0;
            end
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_mask_q    <= '0;
        end else begin
            pend_q      <= bus.rd_en_out;
            pend_side_q <= fetch1;
            wr_en_q     <= 1'b0;
            case (state)
                S_IDLE: if (bus.start_in) begin
                    len_q      <= len_ext;
                    desc_q     <= bus.desc_in;
                    w_q        <= START_IDX;
                    base_q     <= '0;
                    out_idx_q  <= '0;
                    pingpong_q <= 1'b0;
                end
                S_SETUP: begin
                    head_q[0]  <= base_q;
                    end_q[0]   <= min_idx(base_q + w_q, len_q);
                    head_q[1]  <= min_idx(base_q + w_q, len_q);
                    end_q[1]   <= min_idx(base_q + (w_q << 1), len_q);
                    row_v_q[0] <= 1'b0;
                    row_v_q[1] <= 1'b0;
                end
                S_MERGE: begin
                    for (int s = 0; s < 2; s++) begin
                        if (pend_q && pend_side_q == 1'(s)) begin
                            row_q[s]   <= bus.rd_data_in;
                            row_v_q[s] <= 1'b1;
                        end
                    end
                    if (emit) begin
                        head_q[sel] <= head_q[sel] + IW'(1);
                        if (lane_of(head_q[sel]) == LANES - 1) row_v_q[sel] <= 1'b0;
                        out_row_q <= out_row_nxt;
                        out_idx_q <= out_idx_q + IW'(1);
                        if (lane_of(out_idx_q) == LANES - 1) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= row_of(out_idx_q);
                            wr_data_q <= out_row_nxt;
                            wr_mask_q <= '1;
                        end
                    end
                    if (last_emit) base_q <= base_q + (w_q << 1);
                end
                S_FLUSH: if (lane_of(out_idx_q) != 0) begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= row_of(out_idx_q);
                    wr_data_q <= out_row_q;
                    for (int i = 0; i < LANES; i++) wr_mask_q[i] <= (i < lane_of(out_idx_q));
                end
                S_NEXT: begin
                    pingpong_q <= ~pingpong_q;
                    w_q        <= w_q << 1;
                    base_q     <= '0;
                    out_idx_q  <= '0;
                end
                S_DONE:  final_bank_q <= pingpong_q;
                default: ;
            endcase
        end
    end
endmodule
